// File: rtl/sequence_fp_adder.sv
// Multi-cycle floating-point add/subtract unit with round-to-nearest-even.
// Operands and results use valid/ready handshakes; denormal inputs are treated as zero.
module sequence_fp_adder #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [EXP_W+MANT_W:0]   a_i,
  input  logic [EXP_W+MANT_W:0]   b_i,
  input  logic                    op_i,
  input  logic                    vld_i,
  output logic                    rdy_o,
  output logic [EXP_W+MANT_W:0]   res_o,
  output logic [2:0]              status_o,
  output logic                    vld_o,
  input  logic                    rdy_i
);
  localparam int W  = 1 + EXP_W + MANT_W;
  localparam int SW = MANT_W + 4;
  localparam int LW = $clog2(SW + 1);
  localparam int XW = EXP_W + 2;
  localparam logic [EXP_W-1:0] SAT  = EXP_W'(MANT_W + 3);
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ALIGN = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] NORM  = 3'd3;
  localparam logic [2:0] ROUND = 3'd4;
  localparam logic [2:0] OUT   = 3'd5;

  logic [2:0]       state;
  logic [W-1:0]     a_q, b_q;
  logic             op_q;
  logic             sgn_q, sub_q, nz_q, spec_q;
  logic [EXP_W-1:0] exp_q;
  logic [SW-1:0]    ml_q, ms_q;
  logic [W-1:0]     sres_q;
  logic [2:0]       sst_q;
  logic [SW:0]      sum_q;
  logic [SW-1:0]    mn_q;
  logic [XW-1:0]    en_q;
  logic             zero_q, uf_q;
  logic [W-1:0]     res_q;
  logic [2:0]       st_q;

  function automatic logic [LW-1:0] lzc(input logic [SW-1:0] v);
    lzc = LW'(SW);
    for (int i = 0; i < SW; i++)
      if (v[i]) lzc = LW'(SW - 1 - i);
  endfunction

  logic             sa, sb, sl, swap;
  logic [EXP_W-1:0] ea, eb, el, es, dif, sh;
  logic [MANT_W-1:0] fa, fb;
  logic [SW-1:0]    ga, gb, gl, gs, mask, gsh;
  logic             a_nan, b_nan, a_inf, b_inf, nan, inf, sticky;
  logic [W-1:0]     sp_res;
  logic [2:0]       sp_st;

  always_comb begin
    sa = a_q[W-1];
    sb = b_q[W-1] ^ op_q;
    ea = a_q[W-2:MANT_W];
    eb = b_q[W-2:MANT_W];
    fa = a_q[MANT_W-1:0];
    fb = b_q[MANT_W-1:0];
    ga = (ea != '0) ? {1'b1, fa, 3'b000} : '0;
    gb = (eb != '0) ? {1'b1, fb, 3'b000} : '0;
    a_nan = (ea == EMAX) && (fa != '0);
    b_nan = (eb == EMAX) && (fb != '0);
    a_inf = (ea == EMAX) && (fa == '0);
    b_inf = (eb == EMAX) && (fb == '0);
    nan = a_nan || b_nan || (a_inf && b_inf && (sa != sb));
    inf = a_inf || b_inf;
    sp_res = nan ? QNAN : {a_inf ? sa : sb, EMAX, {MANT_W{1'b0}}};
    sp_st = nan ? 3'b001 : 3'b000;
    swap = {eb, gb} > {ea, ga};
    el = swap ? eb : ea;
    es = swap ? ea : eb;
    gl = swap ? gb : ga;
    gs = swap ? ga : gb;
    sl = swap ? sb : sa;
    dif = el - es;
    sh = (dif > SAT) ? SAT : dif;
    // bits pushed past the guard positions collapse into sticky
    mask = ~({SW{1'b1}} << sh);
    sticky = |(gs & mask);
    gsh = (gs >> sh) | {{(SW-1){1'b0}}, sticky};
  end

  logic [LW-1:0] lz;
  logic [SW-1:0] mn_c;
  logic [XW-1:0] en_c;
  logic          zero_c, uf_c;

  always_comb begin
    lz = lzc(sum_q[SW-1:0]);
    if (sum_q[SW]) begin
      mn_c = {sum_q[SW:2], sum_q[1] | sum_q[0]};
      en_c = {2'b00, exp_q} + XW'(1);
    end else begin
      mn_c = sum_q[SW-1:0] << lz;
      en_c = {2'b00, exp_q} - XW'(lz);
    end
    zero_c = (sum_q == '0);
    uf_c = en_c[XW-1] || (en_c == '0);
  end

  logic              up, inx, ovf;
  logic [MANT_W+1:0] rnd;
  logic [MANT_W-1:0] mf;
  logic [XW-1:0]     ef;
  logic [W-1:0]      res_c;
  logic [2:0]        st_c;

  always_comb begin
    up  = mn_q[2] & (mn_q[1] | mn_q[0] | mn_q[3]);
    inx = |mn_q[2:0];
    rnd = {1'b0, mn_q[SW-1:3]} + {{(MANT_W+1){1'b0}}, up};
    ef  = rnd[MANT_W+1] ? en_q + XW'(1) : en_q;
    mf  = rnd[MANT_W+1] ? rnd[MANT_W:1] : rnd[MANT_W-1:0];
    ovf = (ef[XW-1:EXP_W] != '0) || (ef[EXP_W-1:0] == EMAX);
    if (spec_q) begin
      res_c = sres_q;
      st_c  = sst_q;
    end else if (zero_q) begin
      res_c = {nz_q, {(W-1){1'b0}}};
      st_c  = 3'b000;
    end else if (uf_q) begin
      res_c = {sgn_q, {(W-1){1'b0}}};
      st_c  = 3'b100;
    end else if (ovf) begin
      res_c = {sgn_q, EMAX, {MANT_W{1'b0}}};
      st_c  = 3'b110;
    end else begin
      res_c = {sgn_q, ef[EXP_W-1:0], mf};
      st_c  = {inx, 2'b00};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      res_q <= '0;
      st_q  <= '0;
    end else begin
      unique case (state)
        IDLE: if (vld_i) begin
          a_q   <= a_i;
          b_q   <= b_i;
          op_q  <= op_i;
          state <= ALIGN;
        end
        ALIGN: begin
          sgn_q  <= sl;
          exp_q  <= el;
          ml_q   <= gl;
          ms_q   <= gsh;
          sub_q  <= (sa != sb);
          nz_q   <= (ea == '0) && (eb == '0) && sa && sb;
          spec_q <= nan || inf;
          sres_q <= sp_res;
          sst_q  <= sp_st;
          state  <= ADD;
        end
        ADD: begin
          sum_q <= sub_q ? {1'b0, ml_q} - {1'b0, ms_q}
                         : {1'b0, ml_q} + {1'b0, ms_q};
          state <= NORM;
        end
        NORM: begin
          mn_q   <= mn_c;
          en_q   <= en_c;
          zero_q <= zero_c;
          uf_q   <= uf_c;
          state  <= ROUND;
        end
        ROUND: begin
          res_q <= res_c;
          st_q  <= st_c;
          state <= OUT;
        end
        OUT: if (rdy_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rdy_o    = (state == IDLE);
  assign vld_o    = (state == OUT);
  assign res_o    = res_q;
  assign status_o = st_q;
endmodule

// File: tb/tb_sequence_fp_adder.sv
// Scoreboard bench for sequence_fp_adder (float32): directed vectors,
// latency, output back-pressure and mid-operation reset.
module tb_sequence_fp_adder;
  logic        clk = 0;
  logic        rst_i = 1;
  logic [31:0] a_i = '0, b_i = '0;
  logic        op_i = 0, vld_i = 0, rdy_i = 1;
  logic        rdy_o, vld_o;
  logic [31:0] res_o;
  logic [2:0]  status_o;

  sequence_fp_adder dut (
    .clk_i(clk), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .op_i(op_i),
    .vld_i(vld_i), .rdy_o(rdy_o), .res_o(res_o), .status_o(status_o),
    .vld_o(vld_o), .rdy_i(rdy_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  st;
  } exp_t;

  exp_t sb_q[$];
  int   lat_q[$];
  int   total = 0, bad = 0;
  int   cyc = 0, hs_cyc = -1, last_acc = -1;
  logic vld_prev = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (vld_o && !vld_prev) begin
      total++;
      if (lat_q.size() == 0) begin
        bad++;
        $display("FAIL latency: unexpected vld_o at cycle %0d", cyc);
      end else begin
        int acc;
        acc = lat_q.pop_front();
        if (cyc - acc != 5) begin
          bad++;
          $display("FAIL latency: got %0d cycles, need 5", cyc - acc);
        end
      end
    end
    vld_prev = vld_o;
    if (vld_o && rdy_i) begin
      hs_cyc = cyc;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL result: unexpected res=%h st=%b", res_o, status_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (res_o !== e.res || status_o !== e.st) begin
          bad++;
          $display("FAIL result: got res=%h st=%b, need res=%h st=%b",
                   res_o, status_o, e.res, e.st);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] need);
    total++;
    if (got !== need) begin
      bad++;
      $display("FAIL %s: got %h, need %h", name, got, need);
    end
  endtask

  // Entered and left at posedge+2.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic [31:0] r,
                       input logic [2:0] s);
    int n;
    exp_t e;
    a_i = a; b_i = b; op_i = op; vld_i = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy_o && n < 50);
    if (rdy_o) begin
      e.res = r;
      e.st  = s;
      sb_q.push_back(e);
      lat_q.push_back(cyc);
      last_acc = cyc;
    end else begin
      total++;
      bad++;
      $display("FAIL accept: timeout waiting for rdy_o");
    end
    @(posedge clk); #2;
    vld_i = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #2;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d results outstanding", sb_q.size());
      sb_q.delete();
      lat_q.delete();
    end
  endtask

  initial begin
    int n;
    logic [31:0] r0;
    logic [2:0]  s0;
    repeat (3) @(posedge clk);
    #2 rst_i = 0;
    @(negedge clk);
    check("reset rdy_o", 32'(rdy_o), 32'd1);
    check("reset vld_o", 32'(vld_o), 32'd0);
    check("reset res_o", res_o, 32'h0);
    check("reset status_o", 32'(status_o), 32'd0);
    @(posedge clk); #2;

    issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
    issue(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
    issue(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b100);
    issue(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001);
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b110);
    issue(32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 3'b000);
    issue(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000);
    issue(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b100);
    issue(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b100);
    issue(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 3'b100);
    issue(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
    issue(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000);
    issue(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000);
    issue(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001);
    issue(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000);
    issue(32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000, 3'b000);
    issue(32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000);
    issue(32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 3'b100);
    issue(32'h4D800000, 32'h3F800000, 1'b0, 32'h4D800000, 3'b100);
    issue(32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 3'b110);
    drain();

    rdy_i = 0;
    issue(32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 3'b000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vld_o && n < 20);
    check("hold vld_o rise", 32'(vld_o), 32'd1);
    r0 = res_o;
    s0 = status_o;
    repeat (4) begin
      @(negedge clk);
      check("hold vld_o", 32'(vld_o), 32'd1);
      check("hold rdy_o", 32'(rdy_o), 32'd0);
      check("hold res_o", res_o, r0);
      check("hold status_o", 32'(status_o), 32'(s0));
    end
    @(posedge clk); #2;
    rdy_i = 1;
    issue(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000);
    check("accept after handshake", 32'(last_acc), 32'(hs_cyc + 1));
    drain();

    issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
    @(posedge clk); #2;
    rst_i = 1;
    @(posedge clk); #2;
    rst_i = 0;
    void'(sb_q.pop_back());
    void'(lat_q.pop_back());
    @(negedge clk);
    check("abort rdy_o", 32'(rdy_o), 32'd1);
    check("abort vld_o", 32'(vld_o), 32'd0);
    check("abort res_o", res_o, 32'h0);
    repeat (12) @(posedge clk);
    #2;
    issue(32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 3'b000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
